// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter over 32 requesters. The winner is presented as a
// registered 5-bit index for the downstream 5-to-32 decoder. A rotating
// priority pointer makes the arbitration fair.
//
// Handshake: grant_valid/grant_idx are registered. They stay stable while
// grant_valid=1 and grant_ready=0. A grant is accepted on the rising edge
// where grant_valid && grant_ready. grant_ready has no effect while
// grant_valid=0. grant_idx is meaningful only when grant_valid=1.
//
// busy mirrors the FSM (1 in GRANT, 0 in IDLE), so the state is visible
// at the boundary.
module rr_arbiter_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req,
    input  logic        grant_ready,
    output logic        grant_valid,
    output logic [4:0]  grant_idx,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  ptr;
    logic [31:0] rot_req;
    logic [4:0]  rot_idx;
    logic [4:0]  winner;

    // Rotate the requests so that requester ptr sits at bit 0.
    always_comb begin
        rot_req = '0;
        for (int i = 0; i < 32; i++) begin
            rot_req[i] = req[5'(i) + ptr];
        end
    end

    // Find the lowest set bit of the rotated vector, then undo the rotation
    // with a modulo-32 add.
    always_comb begin
        rot_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_idx = 5'(i);
            end
        end
        winner = rot_idx + ptr;
    end

    // Two-state grant FSM with registered outputs and the priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_idx   <= winner;
                        grant_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // The grant is sticky: req is not looked at until the accept.
                    if (grant_ready) begin
                        ptr         <= grant_idx + 5'd1;
                        grant_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Self-checking bench for rr_arbiter_32.
module tb_rr_arbiter_32;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic        grant_ready;
    logic        grant_valid;
    logic [4:0]  grant_idx;
    logic        busy;

    int checks;
    int failures;

    // Model state that the bench tracks from the arbitration rules.
    int          m_ptr;
    logic        m_valid;
    logic [4:0]  m_idx;

    rr_arbiter_32 dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .busy        (busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference winner: the first requester found when scanning upward from p,
    // wrapping past 31 back to 0.
    function automatic logic [4:0] ref_winner(input logic [31:0] r, input int p);
        for (int k = 0; k < 32; k++) begin
            if (r[(p + k) % 32]) return 5'((p + k) % 32);
        end
        return 5'(p % 32);
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_idle();
        req         = '0;
        grant_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        req         = 32'hFFFF_FFFF;
        grant_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b0 || grant_idx !== 5'd0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d: valid=%b idx=%0d busy=%b, expected 0/0/0",
                         c, grant_valid, grant_idx, busy);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 5'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant: valid=%b idx=%0d busy=%b, expected 1/0/1",
                     grant_valid, grant_idx, busy);
        end
        grant_ready = 1'b1;
        tick();
        m_ptr = 1;
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_accept: valid=%b, expected 0", grant_valid);
        end
        go_idle();
    endtask

    task automatic test_single();
        req         = 32'h0000_0080;
        grant_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 5'd7) begin
                failures++;
                $display("FAIL single_grant g=%0d: valid=%b idx=%0d, expected 1/7",
                         g, grant_valid, grant_idx);
            end
            tick();
            m_ptr = 8;
            checks++;
            if (grant_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL single_gap g=%0d: valid=%b busy=%b, expected 0/0",
                         g, grant_valid, busy);
            end
        end
        go_idle();
    endtask

    task automatic test_rotation();
        int seen[32];
        logic [4:0] exp_idx;
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 32; i++) seen[i] = 0;
        req         = 32'hFFFF_FFFF;
        grant_ready = 1'b1;
        for (int g = 0; g < 33; g++) begin
            tick();
            exp_idx = 5'(g % 32);
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== exp_idx) begin
                failures++;
                $display("FAIL rotation g=%0d: valid=%b idx=%0d, expected 1/%0d",
                         g, grant_valid, grant_idx, exp_idx);
            end
            if (g < 32) seen[grant_idx]++;
            m_ptr = (int'(exp_idx) + 1) % 32;
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (seen[i] != 1) begin
                failures++;
                $display("FAIL rotation_once idx=%0d: granted %0d times, expected 1", i, seen[i]);
            end
        end
        go_idle();
    endtask

    task automatic test_wrap();
        logic [4:0] exp_seq[3];
        exp_seq[0] = 5'd3;
        exp_seq[1] = 5'd29;
        exp_seq[2] = 5'd3;
        req         = 32'h2000_0000;
        grant_ready = 1'b1;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 5'd29) begin
            failures++;
            $display("FAIL wrap_setup: valid=%b idx=%0d, expected 1/29", grant_valid, grant_idx);
        end
        tick();
        m_ptr = 30;
        req   = 32'h2000_0008;
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== exp_seq[g]
                || grant_idx !== ref_winner(req, m_ptr)) begin
                failures++;
                $display("FAIL wrap g=%0d: valid=%b idx=%0d, expected 1/%0d",
                         g, grant_valid, grant_idx, exp_seq[g]);
            end
            m_ptr = (int'(exp_seq[g]) + 1) % 32;
            tick();
        end
        go_idle();
    endtask

    task automatic test_backpressure();
        req         = 32'h0000_1000;
        grant_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 5'd12 || busy !== 1'b1) begin
                failures++;
                $display("FAIL sticky cyc=%0d: valid=%b idx=%0d busy=%b, expected 1/12/1",
                         c, grant_valid, grant_idx, busy);
            end
            if (c == 1) req = 32'h0000_0002;
            tick();
        end
        grant_ready = 1'b1;
        tick();
        m_ptr = 13;
        checks++;
        if (grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept: valid=%b, expected 0", grant_valid);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 5'd1) begin
            failures++;
            $display("FAIL bp_next: valid=%b idx=%0d, expected 1/1", grant_valid, grant_idx);
        end
        tick();
        m_ptr = 2;
        go_idle();
    endtask

    task automatic test_reset_mid();
        req         = 32'h0010_0000;
        grant_ready = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 5'd20) begin
            failures++;
            $display("FAIL midrst_setup: valid=%b idx=%0d, expected 1/20", grant_valid, grant_idx);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (grant_valid !== 1'b0 || grant_idx !== 5'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear: valid=%b idx=%0d busy=%b, expected 0/0/0",
                     grant_valid, grant_idx, busy);
        end
        rst   = 1'b0;
        m_ptr = 0;
        req   = 32'h0010_0001;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 5'd0) begin
            failures++;
            $display("FAIL midrst_first: valid=%b idx=%0d, expected 1/0", grant_valid, grant_idx);
        end
        grant_ready = 1'b1;
        tick();
        m_ptr = 1;
        go_idle();
    endtask

    task automatic test_random();
        logic [31:0] r;
        m_valid = 1'b0;
        m_idx   = 5'd0;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = 32'd1 << $urandom_range(0, 31);
                2: r = $urandom() & $urandom();
                default: r = $urandom();
            endcase
            req         = r;
            grant_ready = ($urandom_range(0, 2) != 0);
            if (!m_valid) begin
                if (r != 0) begin
                    m_idx   = ref_winner(r, m_ptr);
                    m_valid = 1'b1;
                end
            end else if (grant_ready) begin
                m_ptr   = (int'(m_idx) + 1) % 32;
                m_valid = 1'b0;
            end
            tick();
            checks++;
            if (grant_valid !== m_valid || grant_idx !== m_idx || busy !== m_valid) begin
                failures++;
                $display("FAIL random cyc=%0d req=%h: valid=%b idx=%0d busy=%b, expected %b/%0d/%b",
                         c, r, grant_valid, grant_idx, busy, m_valid, m_idx, m_valid);
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        m_ptr       = 0;
        m_valid     = 1'b0;
        m_idx       = 5'd0;
        rst         = 1'b1;
        req         = '0;
        grant_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
